// File: rtl/riscv_execute_mdu_pkg.sv
// Shared constants, state type and operand-sign helpers for the execute-stage
// multiply/divide unit.
package riscv_execute_mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic rs1_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
           (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
           (funct3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/riscv_mdu_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply
// (multiplier in lo, LSB first) or restoring shift-subtract for divide.
module riscv_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand} : '0);
    shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      // diff MSB clear means the partial remainder covered the divisor
      if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else             acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_execute_mdu.sv
// Iterative M-extension unit in EX: stalls the pipeline while it iterates on
// operand magnitudes, then pulses a signed-corrected result for one cycle.
module riscv_execute_mdu
  import riscv_execute_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_startE,
  input  logic [2:0]      i_funct3E,
  input  logic [XLEN-1:0] i_rs1_dataE,
  input  logic [XLEN-1:0] i_rs2_dataE,
  input  logic [4:0]      i_rd_addrE,
  input  logic            i_flushE,
  output logic            o_busyE,
  output logic            o_validE,
  output logic [XLEN-1:0] o_resultE,
  output logic [4:0]      o_rd_addrE
);

  localparam int N_ITER = XLEN / UNROLL;
  localparam int CNT_W  = $clog2(N_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              in_is_div, in_neg1, in_neg2;
  logic [XLEN-1:0]   abs1, abs2, special_res;
  logic              div_zero, div_ovf, special, accept, last_iter;
  logic [2*XLEN-1:0] acc_fin, prod;
  logic [XLEN-1:0]   quo, rem, final_res;
  logic [2*XLEN-1:0] chain [0:UNROLL];

  always_comb begin
    in_is_div = i_funct3E[2];
    in_neg1   = rs1_is_signed(i_funct3E) && i_rs1_dataE[XLEN-1];
    in_neg2   = rs2_is_signed(i_funct3E) && i_rs2_dataE[XLEN-1];
    abs1      = in_neg1 ? -i_rs1_dataE : i_rs1_dataE;
    abs2      = in_neg2 ? -i_rs2_dataE : i_rs2_dataE;
    div_zero  = in_is_div && (i_rs2_dataE == '0);
    div_ovf   = ((i_funct3E == FUNCT3_DIV) || (i_funct3E == FUNCT3_REM)) &&
                (i_rs1_dataE == MOST_NEG) && (i_rs2_dataE == '1);
    special   = div_zero || div_ovf;
    if (div_zero) special_res = i_funct3E[1] ? i_rs1_dataE : '1;
    else          special_res = i_funct3E[1] ? '0 : MOST_NEG;
    accept    = i_startE && !i_flushE && (state_q != ST_BUSY);
    last_iter = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
  end

  assign chain[0] = acc_q;
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    riscv_mdu_step #(.XLEN(XLEN)) u_step (
      .is_div  (funct3_q[2]),
      .operand (opnd_q),
      .acc_i   (chain[g]),
      .acc_o   (chain[g+1])
    );
  end

  // neg_q carries the quotient/product sign, or the dividend sign for REM
  always_comb begin
    acc_fin = chain[UNROLL];
    prod    = neg_q ? -acc_fin : acc_fin;
    quo     = neg_q ? -acc_fin[XLEN-1:0] : acc_fin[XLEN-1:0];
    rem     = neg_q ? -acc_fin[2*XLEN-1:XLEN] : acc_fin[2*XLEN-1:XLEN];
    case (funct3_q)
      FUNCT3_MUL:                 final_res = prod[XLEN-1:0];
      FUNCT3_DIV, FUNCT3_DIVU:    final_res = quo;
      FUNCT3_REM, FUNCT3_REMU:    final_res = rem;
      default:                    final_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    funct3_d = funct3_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      ST_BUSY: begin
        acc_d = chain[UNROLL];
        cnt_d = cnt_q + 1'b1;
        if (last_iter && !i_flushE) begin
          result_d = final_res;
          rd_out_d = rd_q;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          funct3_d = i_funct3E;
          rd_d     = i_rd_addrE;
          if (special) begin
            result_d = special_res;
            rd_out_d = i_rd_addrE;
            state_d  = ST_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (in_is_div ? abs1 : abs2)};
            opnd_d  = in_is_div ? abs2 : abs1;
            neg_d   = (in_is_div && i_funct3E[1]) ? in_neg1 : (in_neg1 ^ in_neg2);
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
    endcase
    if (i_flushE) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Busy drops in the final iteration so the stalled instruction advances with valid
  assign o_busyE    = !i_flushE &&
                      (((state_q == ST_BUSY) && !last_iter) || (accept && !special));
  assign o_validE   = (state_q == ST_DONE);
  assign o_resultE  = result_q;
  assign o_rd_addrE = rd_out_q;

endmodule

// File: tb/tb_riscv_execute_mdu.sv
// Directed bench for the M-extension unit: a 32-bit radix-2 instance and a
// 16-bit radix-16 instance driven one at a time.
module tb_riscv_execute_mdu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;

  logic        st32;
  logic [2:0]  f32;
  logic [31:0] a32, b32;
  logic [4:0]  rd32;
  logic        busy32, v32;
  logic [31:0] r32;
  logic [4:0]  rdo32;

  logic        st16;
  logic [2:0]  f16;
  logic [15:0] a16, b16;
  logic [4:0]  rd16;
  logic        busy16, v16;
  logic [15:0] r16;
  logic [4:0]  rdo16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_execute_mdu #(.XLEN(32), .UNROLL(1)) u_dut32 (
    .i_clk(clk), .i_rstn(rstn), .i_startE(st32), .i_funct3E(f32),
    .i_rs1_dataE(a32), .i_rs2_dataE(b32), .i_rd_addrE(rd32), .i_flushE(flush),
    .o_busyE(busy32), .o_validE(v32), .o_resultE(r32), .o_rd_addrE(rdo32)
  );

  riscv_execute_mdu #(.XLEN(16), .UNROLL(4)) u_dut16 (
    .i_clk(clk), .i_rstn(rstn), .i_startE(st16), .i_funct3E(f16),
    .i_rs1_dataE(a16), .i_rs2_dataE(b16), .i_rd_addrE(rd16), .i_flushE(flush),
    .o_busyE(busy16), .o_validE(v16), .o_resultE(r16), .o_rd_addrE(rdo16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an op in the current cycle (cycle 0), counts cycles to valid and
  // busy cycles up to and including the valid cycle.
  task automatic run_op(input bit w16, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int exp_busy, input bit b2b, input string tag);
    int cyc;
    int nb;
    logic bz, vv;
    if (w16) begin
      st16 = 1'b1; f16 = f; a16 = a[15:0]; b16 = b[15:0]; rd16 = rd;
    end else begin
      st32 = 1'b1; f32 = f; a32 = a; b32 = b; rd32 = rd;
    end
    cyc = 0;
    nb  = 0;
    #1;
    while (cyc < 200) begin
      bz = w16 ? busy16 : busy32;
      vv = w16 ? v16 : v32;
      if (bz) nb++;
      if (vv && cyc > 0) break;
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        st16 = 1'b0;
        st32 = 1'b0;
      end
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_result"}, w16 ? {16'h0, r16} : r32, exp_res);
    chk({tag, "_rd"}, w16 ? {27'h0, rdo16} : {27'h0, rdo32}, {27'h0, rd});
    if (!b2b) begin
      @(posedge clk);
      #1;
      chk({tag, "_valid_pulse"}, w16 ? {31'h0, v16} : {31'h0, v32}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rstn = 1'b0; flush = 1'b0;
    st32 = 1'b0; f32 = 3'd0; a32 = '0; b32 = '0; rd32 = '0;
    st16 = 1'b0; f16 = 3'd0; a16 = '0; b16 = '0; rd16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, v32}, 32'h0);
    chk("reset_busy", {31'h0, busy32}, 32'h0);
    chk("reset_result", r32, 32'h0);
    chk("reset_rd", {27'h0, rdo32}, 32'h0);
    chk("reset_result16", {16'h0, r16}, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 32, 0, "mul_7xm3");
    run_op(0, 3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 5'd6,  32'h0000000F, 33, 32, 0, "mul_m3xm5");
    run_op(0, 3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33, 32, 0, "mulh_min");
    run_op(0, 3'b001, 32'hFFFFFFFD, 32'h00000005, 5'd8,  32'hFFFFFFFF, 33, 32, 0, "mulh_neg");
    run_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF, 33, 32, 0, "mulhsu");
    run_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 33, 32, 0, "mulhu");
    run_op(0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFD, 33, 32, 0, "div_m7_2");
    run_op(0, 3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd12, 32'hFFFFFFFF, 33, 32, 0, "rem_m7_2");
    run_op(0, 3'b100, 32'h00000007, 32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 33, 32, 0, "div_7_m2");
    run_op(0, 3'b110, 32'h00000007, 32'hFFFFFFFE, 5'd14, 32'h00000001, 33, 32, 0, "rem_7_m2");
    run_op(0, 3'b101, 32'd100,      32'd7,        5'd15, 32'd14,       33, 32, 0, "divu_100_7");
    run_op(0, 3'b111, 32'd100,      32'd7,        5'd16, 32'd2,        33, 32, 0, "remu_100_7");
    run_op(0, 3'b101, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1,  0,  0, "divu_by0");
    run_op(0, 3'b110, 32'd5,        32'd0,        5'd18, 32'd5,        1,  0,  0, "rem_by0");
    run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1,  0,  0, "div_ovf");
    run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1,  0,  0, "rem_ovf");

    // back-to-back: second op is started in the first op's valid cycle
    run_op(0, 3'b000, 32'd3,   32'd4, 5'd21, 32'd12, 33, 32, 1, "b2b_first");
    run_op(0, 3'b101, 32'd100, 32'd7, 5'd22, 32'd14, 33, 32, 0, "b2b_second");

    // flush in the tenth BUSY cycle
    st32 = 1'b1; f32 = 3'b000; a32 = 32'd9; b32 = 32'd9; rd32 = 5'd23;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_busy_low", {31'h0, busy32}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    nv = 0;
    repeat (40) begin
      #1;
      if (v32) nv++;
      @(posedge clk);
      #1;
    end
    chk("flush_no_valid", nv, 0);
    chk("flush_idle_busy", {31'h0, busy32}, 32'h0);
    chk("flush_result_held", r32, 32'd14);

    // flush beats a simultaneous start
    st32 = 1'b1; flush = 1'b1; f32 = 3'b101; a32 = 32'd50; b32 = 32'd5; rd32 = 5'd24;
    #1;
    chk("flush_start_busy", {31'h0, busy32}, 32'h0);
    @(posedge clk);
    #1;
    st32 = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_no_valid", {31'h0, v32}, 32'h0);
    chk("flush_start_no_busy", {31'h0, busy32}, 32'h0);

    // asynchronous reset in the middle of an operation
    st32 = 1'b1; f32 = 3'b101; a32 = 32'd1000; b32 = 32'd3; rd32 = 5'd25;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, v32}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy32}, 32'h0);
    chk("rst_mid_result", r32, 32'h0);
    chk("rst_mid_rd", {27'h0, rdo32}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    nv = 0;
    repeat (40) begin
      #1;
      if (v32) nv++;
      @(posedge clk);
      #1;
    end
    chk("rst_mid_no_valid", nv, 0);
    run_op(0, 3'b011, 32'h00010000, 32'h00010000, 5'd26, 32'h00000001, 33, 32, 0, "post_rst_mulhu");

    // 16-bit, four bits per iteration
    run_op(1, 3'b000, 32'h1234, 32'h0010, 5'd1, 32'h2340, 5, 4, 0, "w16_mul");
    run_op(1, 3'b001, 32'h8000, 32'h8000, 5'd2, 32'h4000, 5, 4, 0, "w16_mulh");
    run_op(1, 3'b100, 32'hFFF9, 32'h0002, 5'd3, 32'hFFFD, 5, 4, 0, "w16_div");
    run_op(1, 3'b111, 32'd100,  32'd7,    5'd4, 32'd2,    5, 4, 0, "w16_remu");
    run_op(1, 3'b101, 32'd5,    32'd0,    5'd5, 32'hFFFF, 1, 0, 0, "w16_divu_by0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_execute_mdu.md
Name: riscv_execute_mdu

Overview:
- Parametrised iterative M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) placed in the execute stage beside the ALU.
- Operands arrive after the forwarding muxes.
- Raises a stall request to the hazard unit while computing, then presents a one-cycle valid result, destination address and tag toward the EX/MEM register.
- Generalises the single-cycle execute datapath with configurable width, configurable iteration radix, and multi-cycle handshake, flush and special-case handling.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.
- UNROLL, 1, bits processed per iteration (1, 2 or 4); XLEN % UNROLL must equal 0.
- N_ITER, XLEN/UNROLL, derived localparam: iteration count.

Ports:
- i_clk  in  1  core clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_startE  in  1  M-op present in EX this cycle (decoded funct7=0000001, OP opcode).
- i_funct3E  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1_dataE  in  XLEN  forwarded SrcA (multiplicand / dividend).
- i_rs2_dataE  in  XLEN  forwarded write-data operand (multiplier / divisor).
- i_rd_addrE  in  5  destination register.
- i_flushE  in  1  synchronous abort from the hazard unit.
- o_busyE  out  1  stall request to the hazard unit (holds F/D/E).
- o_validE  out  1  result valid, one-cycle pulse.
- o_resultE  out  XLEN  result.
- o_rd_addrE  out  5  destination register of the result.

Behaviour:
- **Reset:** async on i_rstn=0. State=IDLE, counter=0, o_validE=0, o_resultE=0, o_rd_addrE=0, all internal accumulators 0. Reset mid-operation discards the operation with no valid pulse.
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - i_startE=1 and i_flushE=0: latch operands, funct3 and rd.
  - Special case (divisor==0, or signed DIV/REM with rs1=most-negative and rs2=-1): result computed directly, go to DONE.
  - Otherwise: load absolute values (signed ops only), counter=0, go to BUSY.
- **BUSY:**
  - Each cycle performs UNROLL shift-add (mul) or restoring shift-subtract (div) steps; counter++.
  - When counter==N_ITER-1: apply sign correction, select the low/high half (mul) or quotient/remainder (div), register into o_resultE, go to DONE.
  - i_startE is ignored while BUSY.
- **DONE:**
  - o_validE=1 for exactly this cycle; o_resultE/o_rd_addrE hold until the next completion.
  - If i_startE=1 here: accept the new op (back-to-back) as in IDLE; otherwise go to IDLE.
- **o_busyE** is combinational:
  - 1 in IDLE/DONE when i_startE=1, i_flushE=0 and the op is not a special case.
  - 1 in BUSY, except in the final BUSY cycle (counter==N_ITER-1), where it is 0 so the pipeline advances into DONE in step with valid.
  - 0 otherwise.
- **Latency:** normal op, start at cycle 0 → o_validE at cycle N_ITER+1. Special case → o_validE at cycle 1.
- **Special-case results:**
  - DIV/DIVU by 0 → all-ones; REM/REMU by 0 → rs1.
  - DIV overflow → most-negative; REM overflow → 0.
- **Sign rules:**
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU / MUL low half: unsigned magnitude path with final 2XLEN negate as required.
  - Quotient is negative when the operand signs differ; remainder takes the dividend's sign.
- **Flush:** i_flushE=1 in any state → next state IDLE, no valid pulse, o_busyE=0 that cycle; flush overrides a simultaneous start.
- **Product:** 2·XLEN-bit internal accumulator; no truncation until the final select.

Decomposition:
- Add FUNCT3_MUL…FUNCT3_REMU and FUNCT7_MULDIV constants to riscv_configs.v.
- State encodings are local localparams.
- Sub-module riscv_mdu_step: one combinational radix-2 iteration (mode input mul/div). It is instantiated UNROLL times in a chain inside the BUSY datapath.

Test Plan:
- XLEN=32, UNROLL=1, MUL rs1=7, rs2=0xFFFFFFFD → o_busyE high cycles 0–31, o_validE at cycle 33, result 0xFFFFFFEB, rd echoed.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 with o_validE at cycle 1 and o_busyE never high.
- Flush at BUSY cycle 10 → no o_validE, o_busyE low same cycle. A start at the DONE cycle → second result at N_ITER+1 cycles later. i_rstn low mid-BUSY → all outputs 0 immediately.
- UNROLL=4 and XLEN=16 regressions: MUL 0x1234×0x0010 → 0x2340, validE at cycle 5; random signed/unsigned ops vs reference model, 10k ops.
